// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one holding slot per unit, one registered broadcast per cycle (CDB_BYPASS_EN adds same-cycle bypass).
// Latency 2 edges capture->broadcast (1 with bypass); fu_ready deasserts only for a full slot that is not granted this cycle.
module cdb_arbiter #(
  parameter int NUM_UNITS = 8,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 3
) (
  input  logic                        CLOCK_50,
  input  logic                        RSTN_N,
  input  logic                        flush,
  input  logic [NUM_UNITS-1:0]        fu_valid,
  input  logic [NUM_UNITS*DATA_W-1:0] fu_result,
  output logic [NUM_UNITS-1:0]        fu_ready,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic                        cdb_busy
);

  // Tag 0 means "value ready", so unit 0 never owns a slot.
  localparam logic [NUM_UNITS-1:0] UNIT_MASK = {{(NUM_UNITS-1){1'b1}}, 1'b0};

  logic [NUM_UNITS-1:0] full;
  logic [DATA_W-1:0]    slot_data [NUM_UNITS];
  logic [TAG_W-1:0]     ptr;

  logic [NUM_UNITS-1:0] cand;
  logic [NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0] bypass_hit;
  logic [NUM_UNITS-1:0] capture;
  logic [TAG_W:0]       scan_idx;
  logic [TAG_W-1:0]     win_idx;
  logic [TAG_W-1:0]     ptr_next;
  logic                 win_vld;
  logic [DATA_W-1:0]    win_data;

`ifdef CDB_BYPASS_EN
  // An empty slot is always ready, so a valid unit with an empty slot is a candidate.
  assign cand       = (full | fu_valid) & UNIT_MASK;
  assign bypass_hit = grant & ~full;
`else
  assign cand       = full & UNIT_MASK;
  assign bypass_hit = '0;
`endif

  // Scan from ptr upward over units 1..NUM_UNITS-1, wrapping past index 0.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_UNITS - 1; k++) begin
      scan_idx = {1'b0, ptr} + (TAG_W+1)'(k);
      if (scan_idx >= (TAG_W+1)'(NUM_UNITS))
        scan_idx = scan_idx - (TAG_W+1)'(NUM_UNITS - 1);
      if (!win_vld && cand[scan_idx[TAG_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = scan_idx[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (win_vld)
      grant[win_idx] = 1'b1;
  end

  always_comb begin
    win_data = slot_data[win_idx];
    if (bypass_hit[win_idx])
      win_data = fu_result[win_idx*DATA_W +: DATA_W];
  end

  assign ptr_next = (win_idx == TAG_W'(NUM_UNITS - 1)) ? TAG_W'(1) : win_idx + 1'b1;

  assign fu_ready = (~full | grant) & UNIT_MASK;
  assign capture  = fu_valid & fu_ready & ~bypass_hit & {NUM_UNITS{~flush}};
  assign cdb_busy = |(full & UNIT_MASK);

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      full      <= '0;
      ptr       <= TAG_W'(1);
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
    end else if (flush) begin
      full      <= '0;
      cdb_valid <= 1'b0;
    end else begin
      full <= (full & ~grant) | capture;
      if (win_vld) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= win_idx;
        cdb_data  <= win_data;
        ptr       <= ptr_next;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      for (int i = 0; i < NUM_UNITS; i++)
        slot_data[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++)
        if (capture[i])
          slot_data[i] <= fu_result[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, corner sequences, and random traffic against a queue-free slot model.
module tb_cdb_arbiter;

  localparam int NU = 8;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          CLOCK_50;
  logic          RSTN_N;
  logic          flush;
  logic [7:0]    fu_valid;
  logic [255:0]  fu_result;
  logic [7:0]    fu_ready;
  logic          cdb_valid;
  logic [2:0]    cdb_tag;
  logic [31:0]   cdb_data;
  logic          cdb_busy;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_UNITS(8), .DATA_W(32), .TAG_W(3)) dut (
    .CLOCK_50  (CLOCK_50),
    .RSTN_N    (RSTN_N),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_result (fu_result),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_busy  (cdb_busy)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish act=running exp=done");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic            flush;
    logic [7:0]      vld;
    logic [7:0][7:0] lanes;
    logic [7:0]      rdy;
    logic            cv;
    logic [2:0]      tag;
    logic [7:0]      dat;
    logic            busy;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: per-unit occupancy and value, pointer kept as a plain integer.
  bit          m_full [NU];
  logic [31:0] m_val  [NU];
  int          m_ptr;
  bit          m_cv;
  logic [2:0]  m_tag;
  logic [31:0] m_dat;

  function automatic void m_reset();
    for (int u = 0; u < NU; u++) begin
      m_full[u] = 1'b0;
      m_val[u]  = '0;
    end
    m_ptr = 1;
    m_cv  = 1'b0;
    m_tag = '0;
    m_dat = '0;
  endfunction

  function automatic int m_winner(input logic [7:0] vld);
    for (int k = 0; k < NU - 1; k++) begin
      int u;
      u = ((m_ptr - 1 + k) % (NU - 1)) + 1;
      if (m_full[u] || (BYP && vld[u]))
        return u;
    end
    return 0;
  endfunction

  function automatic logic [7:0] m_ready(input logic [7:0] vld);
    logic [7:0] r;
    int w;
    w = m_winner(vld);
    r = '0;
    for (int u = 1; u < NU; u++)
      r[u] = !m_full[u] || (w == u);
    return r;
  endfunction

  function automatic void m_commit(input logic fl, input logic [7:0] vld, input logic [255:0] res);
    int w;
    logic [7:0] r;
    bit was_full [NU];
    w = m_winner(vld);
    r = m_ready(vld);
    for (int u = 0; u < NU; u++) was_full[u] = m_full[u];
    if (fl) begin
      for (int u = 0; u < NU; u++) m_full[u] = 1'b0;
      m_cv = 1'b0;
      return;
    end
    if (w != 0) begin
      m_cv  = 1'b1;
      m_tag = 3'(w);
      m_dat = was_full[w] ? m_val[w] : res[w*32 +: 32];
      m_full[w] = 1'b0;
      m_ptr = (w % (NU - 1)) + 1;
    end else begin
      m_cv = 1'b0;
    end
    for (int u = 1; u < NU; u++)
      if (vld[u] && r[u] && !(w == u && !was_full[u])) begin
        m_full[u] = 1'b1;
        m_val[u]  = res[u*32 +: 32];
      end
  endfunction

  function automatic logic m_busy();
    logic b;
    b = 1'b0;
    for (int u = 1; u < NU; u++) b = b | m_full[u];
    return b;
  endfunction

  task automatic do_reset();
    RSTN_N    = 1'b0;
    flush     = 1'b0;
    fu_valid  = '0;
    fu_result = '0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    RSTN_N = 1'b1;
    m_reset();
  endtask

  task automatic drive_lanes(input logic [7:0] vld, input logic [7:0][7:0] lanes, input logic fl);
    flush    = fl;
    fu_valid = vld;
    for (int i = 0; i < NU; i++)
      fu_result[i*32 +: 32] = {24'h0, lanes[i]};
  endtask

  task automatic run_row(input vec_t v, input int r);
    drive_lanes(v.vld, v.lanes, v.flush);
    #1;
    chk($sformatf("row%0d_ready", r), {24'h0, fu_ready}, {24'h0, v.rdy});
    @(posedge CLOCK_50);
    #1;
    chk($sformatf("row%0d_cdb_valid", r), {31'h0, cdb_valid}, {31'h0, v.cv});
    if (v.cv) begin
      chk($sformatf("row%0d_cdb_tag", r), {29'h0, cdb_tag}, {29'h0, v.tag});
      chk($sformatf("row%0d_cdb_data", r), cdb_data, {24'h0, v.dat});
    end
    chk($sformatf("row%0d_cdb_busy", r), {31'h0, cdb_busy}, {31'h0, v.busy});
  endtask

  initial begin
    vec_t        tbl [22];
    bit          pend [NU];
    logic [31:0] pval [NU];
    logic [7:0]  exp_rdy;

    // Expected values assume the default build (no bypass).
    tbl[0]  = '{1'b0, 8'h00, 64'h00_00_00_00_00_00_00_00, 8'hFE, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h92, 64'h77_00_00_44_00_00_11_00, 8'hFE, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 64'h0,                       8'h6E, 1'b1, 3'd1, 8'h11, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 64'h0,                       8'h7E, 1'b1, 3'd4, 8'h44, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 64'h0,                       8'hFE, 1'b1, 3'd7, 8'h77, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 64'h0,                       8'hFE, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h08, 64'h00_00_00_00_05_00_00_00, 8'hFE, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 64'h0,                       8'hFE, 1'b1, 3'd3, 8'h05, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 64'h0,                       8'hFE, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 8'h20, 64'h00_00_55_00_00_00_00_00, 8'hFE, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 64'h0,                       8'hFE, 1'b1, 3'd5, 8'h55, 1'b0};
    tbl[11] = '{1'b0, 8'h44, 64'h00_66_00_00_00_22_00_00, 8'hFE, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[12] = '{1'b0, 8'h00, 64'h0,                       8'hFA, 1'b1, 3'd6, 8'h66, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 64'h0,                       8'hFE, 1'b1, 3'd2, 8'h22, 1'b0};
    tbl[14] = '{1'b0, 8'h20, 64'h00_00_0A_00_00_00_00_00, 8'hFE, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[15] = '{1'b0, 8'h20, 64'h00_00_0B_00_00_00_00_00, 8'hFE, 1'b1, 3'd5, 8'h0A, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 64'h0,                       8'hFE, 1'b1, 3'd5, 8'h0B, 1'b0};
    tbl[17] = '{1'b0, 8'h0C, 64'h00_00_00_00_33_22_00_00, 8'hFE, 1'b0, 3'd0, 8'h00, 1'b1};
    tbl[18] = '{1'b1, 8'h40, 64'h00_66_00_00_00_00_00_00, 8'hF6, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 64'h0,                       8'hFE, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[20] = '{1'b0, 8'h01, 64'h00_00_00_00_00_00_00_99, 8'hFE, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[21] = '{1'b0, 8'h00, 64'h0,                       8'hFE, 1'b0, 3'd0, 8'h00, 1'b0};

    RSTN_N    = 1'b0;
    flush     = 1'b0;
    fu_valid  = '0;
    fu_result = '0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("reset_cdb_valid", {31'h0, cdb_valid}, 32'h0);
    chk("reset_cdb_tag",   {29'h0, cdb_tag},   32'h0);
    chk("reset_cdb_data",  cdb_data,           32'h0);
    chk("reset_fu_ready",  {24'h0, fu_ready},  32'hFE);
    chk("reset_cdb_busy",  {31'h0, cdb_busy},  32'h0);
    RSTN_N = 1'b1;
    m_reset();

`ifndef CDB_BYPASS_EN
    for (int r = 0; r < 22; r++)
      run_row(tbl[r], r);
`else
    // Bypass: a lone result broadcasts on its capture edge and never occupies the slot.
    drive_lanes(8'h08, 64'h00_00_00_00_05_00_00_00, 1'b0);
    #1;
    chk("byp_single_ready", {24'h0, fu_ready}, 32'hFE);
    @(posedge CLOCK_50); #1;
    chk("byp_single_valid", {31'h0, cdb_valid}, 32'h1);
    chk("byp_single_tag",   {29'h0, cdb_tag},   32'h3);
    chk("byp_single_data",  cdb_data,           32'h5);
    chk("byp_single_busy",  {31'h0, cdb_busy},  32'h0);
    drive_lanes(8'h00, 64'h0, 1'b0);
    @(posedge CLOCK_50); #1;
    chk("byp_single_idle",  {31'h0, cdb_valid}, 32'h0);
    drive_lanes(8'h40, 64'h00_66_00_00_00_00_00_00, 1'b1);
    @(posedge CLOCK_50); #1;
    chk("byp_flush_valid",  {31'h0, cdb_valid}, 32'h0);
    chk("byp_flush_busy",   {31'h0, cdb_busy},  32'h0);
    drive_lanes(8'h00, 64'h0, 1'b0);
    @(posedge CLOCK_50); #1;
    chk("byp_flush_after",  {31'h0, cdb_valid}, 32'h0);
`endif

    // Asynchronous reset in the middle of a broadcast burst.
    drive_lanes(8'h92, 64'h77_00_00_44_00_00_11_00, 1'b0);
    @(posedge CLOCK_50); #1;
    drive_lanes(8'h00, 64'h0, 1'b0);
    @(posedge CLOCK_50); #1;
    chk("midrst_pre_valid", {31'h0, cdb_valid}, 32'h1);
    #3;
    RSTN_N = 1'b0;
    #1;
    chk("midrst_cdb_valid", {31'h0, cdb_valid}, 32'h0);
    chk("midrst_cdb_tag",   {29'h0, cdb_tag},   32'h0);
    chk("midrst_cdb_data",  cdb_data,           32'h0);
    chk("midrst_fu_ready",  {24'h0, fu_ready},  32'hFE);
    chk("midrst_cdb_busy",  {31'h0, cdb_busy},  32'h0);

    // Random traffic: each unit holds its result until the model says it was accepted.
    do_reset();
    for (int u = 0; u < NU; u++) begin
      pend[u] = 1'b0;
      pval[u] = '0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int u = 1; u < NU; u++) begin
        if (!pend[u] && $urandom_range(0, 2) == 0) begin
          pend[u] = 1'b1;
          pval[u] = $urandom;
        end
        fu_valid[u] = pend[u];
        fu_result[u*32 +: 32] = pend[u] ? pval[u] : $urandom;
      end
      fu_valid[0]        = 1'($urandom_range(0, 1));
      fu_result[31:0]    = $urandom;
      flush              = ($urandom_range(0, 24) == 0);
      #1;
      exp_rdy = m_ready(fu_valid);
      chk($sformatf("rand%0d_ready", c), {24'h0, fu_ready}, {24'h0, exp_rdy});
      @(posedge CLOCK_50);
      m_commit(flush, fu_valid, fu_result);
      for (int u = 1; u < NU; u++)
        if (pend[u] && exp_rdy[u] && !flush)
          pend[u] = 1'b0;
      #1;
      chk($sformatf("rand%0d_cdb_valid", c), {31'h0, cdb_valid}, {31'h0, m_cv});
      if (m_cv) begin
        chk($sformatf("rand%0d_cdb_tag", c), {29'h0, cdb_tag}, {29'h0, m_tag});
        chk($sformatf("rand%0d_cdb_data", c), cdb_data, m_dat);
      end
      chk($sformatf("rand%0d_cdb_busy", c), {31'h0, cdb_busy}, {31'h0, m_busy()});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
